aes_ctr_sequencer: RTL
======================

Name: aes_ctr_sequencer

Overview:
Controls an AES-256 block-cipher core for CTR mode. Each packet starts from an initial counter block loaded at configuration. The block issues counter blocks to the core ahead of demand, buffers the returned keystream, XORs it with the plaintext AXI-Stream and drives the ciphertext AXI-Stream. It sits between the plaintext producer, the AES core and the ciphertext consumer.

Parameters:
DATA_WIDTH, 128, width of the block, counter and stream data (fixed at 128 for AES).
CTR_WIDTH, 32, number of low counter bits that increment; the upper bits are held constant.
KS_DEPTH, 8, keystream FIFO depth; also the maximum of (outstanding requests + stored keystream). Power of two, 2 to 64.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
cfg_start  in  1  start a packet; sampled only in IDLE
cfg_iv  in  128  initial counter block, captured with cfg_start
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse when a packet completes
err_overflow  out  1  sticky; set if a core response arrives while the FIFO is full
blocks_done  out  32  count of ciphertext words delivered since reset, wraps
core_req_data  out  128  counter block to be encrypted
core_req_valid  out  1  request valid
core_req_ready  in  1  core accepts request
core_rsp_data  in  128  keystream, returned in request order
core_rsp_valid  in  1  keystream valid; the core cannot be stalled
s_axis_tdata  in  128  plaintext
s_axis_tvalid  in  1
s_axis_tlast  in  1
s_axis_tready  out  1
m_axis_tdata  out  128  ciphertext
m_axis_tvalid  out  1
m_axis_tlast  out  1
m_axis_tready  in  1

Behaviour:
- Reset values: all outputs 0, err_overflow 0, FIFO empty, outstanding=0, state IDLE, counter 0. All of this is restored immediately on rst assertion, including mid-packet. The core is reset by the same rst.
- States: IDLE, RUN, FLUSH.
- IDLE:
  - cfg_start=1 loads ctr<=cfg_iv and moves to RUN on the next edge.
  - cfg_start is ignored in RUN and FLUSH.
- Credit: issue is allowed when outstanding + fifo_count < KS_DEPTH, the state is RUN, and packet tlast has not been accepted.
  - core_req_valid is registered and follows the issue condition.
  - core_req_data = ctr.
  - While core_req_valid=1 and core_req_ready=0, valid and data hold stable.
- On a request handshake:
  - outstanding += 1.
  - ctr[CTR_WIDTH-1:0] += 1 modulo 2^CTR_WIDTH.
  - ctr[127:CTR_WIDTH] is unchanged.
- core_rsp_valid pushes core_rsp_data into the FIFO and decrements outstanding.
  - A request handshake and a response in the same cycle leave outstanding unchanged.
  - A response arriving while the FIFO is full sets err_overflow and the data is dropped. This is unreachable under correct credit accounting.
- s_axis_tready = (state==RUN) && fifo_not_empty && (!m_axis_tvalid || m_axis_tready). It is combinational.
- On an s_axis handshake, at the next edge:
  - Pop the FIFO head.
  - m_axis_tdata <= s_axis_tdata ^ head; m_axis_tlast <= s_axis_tlast; m_axis_tvalid <= 1.
  - Latency from plaintext accept to ciphertext valid is 1 cycle.
  - Full throughput is 1 word/cycle when the core sustains it.
- FIFO push and pop in the same cycle is legal, including push into a full FIFO while it pops. The count is unchanged.
- m_axis_tvalid clears on an m_axis handshake unless it is reloaded in the same cycle. tdata and tlast hold while tvalid=1 and tready=0.
- blocks_done increments on each m_axis handshake.
- An s_axis handshake with tlast=1 moves the state to FLUSH. No further requests issue, and s_axis_tready=0.
- FLUSH:
  - Keystream words already in the FIFO or arriving later are popped and discarded.
  - The block leaves FLUSH when outstanding==0, the FIFO is empty and m_axis_tvalid==0 (last word delivered). It then pulses done for 1 cycle and enters IDLE.
  - The counter is not carried to the next packet; the next packet requires a new cfg_start.
- A zero-length packet is impossible; every packet contains at least one word with tlast.

Test Plan:
- Bench core model: latency 4 cycles, keystream = counter block. cfg_iv=0, plaintext words 0,0,0 with tlast on word 3 -> ciphertext 0x0, 0x1, 0x2; m_axis_tlast on the third word; done pulses once; blocks_done=3.
- Counter wrap: cfg_iv=0x0123456789abcdef_00000000_fffffffe, 4 words -> requests carry low word fffffffe, ffffffff, 00000000, 00000001. Upper 96 bits stay unchanged.
- Backpressure: m_axis_tready toggling 1-0-0-1 and core_req_ready low 3 of every 4 cycles over 20 words -> ciphertext matches the reference XOR. core_req_valid never exceeds KS_DEPTH=8 outstanding plus stored. err_overflow stays 0.
- Flush: 2-word packet with the core stalled to keep 6 requests outstanding -> state stays FLUSH until all 6 responses are discarded, then done. A second packet with cfg_iv=0x10 produces ciphertext starting at 0x10 with no stale keystream.
- Reset mid-packet after 5 words: assert rst for 1 cycle -> busy, m_axis_tvalid, core_req_valid and s_axis_tready are 0 immediately. A new packet then runs correctly.
- cfg_start pulsed during RUN with a different IV -> ignored; ciphertext continues from the original counter.

Source files
------------

// File: rtl/aes_ctr_sequencer.sv
// aes_ctr_sequencer: CTR-mode sequencer for an AES-256 core.
// Issues counter blocks ahead of demand, buffers returned keystream in a FIFO,
// and XORs it onto the plaintext stream to produce the ciphertext stream.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   cfg_start, cfg_iv             packet start and initial counter block (IDLE only)
//   busy, done, err_overflow      status: not idle, completion pulse, sticky FIFO overflow
//   blocks_done                   ciphertext words delivered since reset (wraps)
//   core_req_*                    counter blocks to the core (valid/ready)
//   core_rsp_*                    keystream from the core, in order, cannot be stalled
//   s_axis_*                      plaintext in
//   m_axis_*                      ciphertext out
module aes_ctr_sequencer #(
    parameter int DATA_WIDTH = 128,
    parameter int CTR_WIDTH  = 32,
    parameter int KS_DEPTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_start,
    input  logic [DATA_WIDTH-1:0] cfg_iv,
    output logic                  busy,
    output logic                  done,
    output logic                  err_overflow,
    output logic [31:0]           blocks_done,
    output logic [DATA_WIDTH-1:0] core_req_data,
    output logic                  core_req_valid,
    input  logic                  core_req_ready,
    input  logic [DATA_WIDTH-1:0] core_rsp_data,
    input  logic                  core_rsp_valid,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready
);
    localparam int AW = $clog2(KS_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] ctr_q, ctr_d;
    logic [CW-1:0]         out_q, out_d, cnt_q, cnt_d;
    logic [AW-1:0]         rd_q, wr_q;
    logic [DATA_WIDTH-1:0] mem_q [KS_DEPTH];
    logic                  req_valid_q, req_valid_d;
    logic                  m_valid_q, m_valid_d, m_last_q, m_last_d;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic                  done_q, done_d, err_q, err_d;
    logic [31:0]           blocks_q, blocks_d;
    logic                  req_hs, s_hs, m_hs, fifo_empty, fifo_full, pop, push, flush_exit;
    logic [CW:0]           credit;

    assign fifo_empty     = cnt_q == '0;
    assign fifo_full      = cnt_q == CW'(KS_DEPTH);
    assign s_axis_tready  = state_q == RUN && !fifo_empty && (!m_valid_q || m_axis_tready);
    assign req_hs         = req_valid_q && core_req_ready;
    assign s_hs           = s_axis_tvalid && s_axis_tready;
    assign m_hs           = m_valid_q && m_axis_tready;
    // In FLUSH every keystream word is discarded as soon as it reaches the FIFO head.
    assign pop            = s_hs || (state_q == FLUSH && !fifo_empty);
    // A full FIFO still accepts a push when it pops in the same cycle.
    assign push           = core_rsp_valid && (!fifo_full || pop);
    // A request still held on the interface will produce a response, so it blocks exit too.
    assign flush_exit     = state_q == FLUSH && out_q == '0 && fifo_empty && !m_valid_q && !req_valid_q;

    assign busy           = state_q != IDLE;
    assign done           = done_q;
    assign err_overflow   = err_q;
    assign blocks_done    = blocks_q;
    assign core_req_data  = ctr_q;
    assign core_req_valid = req_valid_q;
    assign m_axis_tdata   = m_data_q;
    assign m_axis_tvalid  = m_valid_q;
    assign m_axis_tlast   = m_last_q;

    always_comb begin
        state_d     = state_q == IDLE && cfg_start ? RUN :
                      state_q == RUN && s_hs && s_axis_tlast ? FLUSH :
                      flush_exit ? IDLE : state_q;
        ctr_d       = state_q == IDLE && cfg_start ? cfg_iv :
                      req_hs ? {ctr_q[DATA_WIDTH-1:CTR_WIDTH], ctr_q[CTR_WIDTH-1:0] + CTR_WIDTH'(1)} : ctr_q;
        out_d       = out_q + CW'(req_hs) - CW'(core_rsp_valid);
        cnt_d       = cnt_q + CW'(push) - CW'(pop);
        credit      = {1'b0, out_d} + {1'b0, cnt_d};
        // A pending request keeps its credit; a new one needs room for outstanding + stored.
        req_valid_d = (req_valid_q && !core_req_ready) ||
                      (state_q == RUN && state_d == RUN && credit < (CW+1)'(KS_DEPTH));
        m_valid_d   = s_hs || (m_valid_q && !m_axis_tready);
        m_data_d    = s_hs ? s_axis_tdata ^ mem_q[rd_q] : m_data_q;
        m_last_d    = s_hs ? s_axis_tlast : m_last_q;
        blocks_d    = blocks_q + 32'(m_hs);
        err_d       = err_q || (core_rsp_valid && !push);
        done_d      = flush_exit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ctr_q       <= '0;
            out_q       <= '0;
            cnt_q       <= '0;
            rd_q        <= '0;
            wr_q        <= '0;
            req_valid_q <= 1'b0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            m_data_q    <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            blocks_q    <= '0;
        end else begin
            state_q     <= state_d;
            ctr_q       <= ctr_d;
            out_q       <= out_d;
            cnt_q       <= cnt_d;
            rd_q        <= rd_q + AW'(pop);
            wr_q        <= wr_q + AW'(push);
            req_valid_q <= req_valid_d;
            m_valid_q   <= m_valid_d;
            m_last_q    <= m_last_d;
            m_data_q    <= m_data_d;
            done_q      <= done_d;
            err_q       <= err_d;
            blocks_q    <= blocks_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= core_rsp_data;
    end
endmodule
